// File: rtl/phy_rx_unstriping_if.sv
// Byte-stream input and four-lane output bundle of the RX un-striping stage.
// The master side feeds striped bytes; the slave side returns the un-striped lanes.
interface phy_rx_unstriping_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] out0;
    logic [DATA_WIDTH-1:0] out1;
    logic [DATA_WIDTH-1:0] out2;
    logic [DATA_WIDTH-1:0] out3;
    logic                  valid_out0;
    logic                  valid_out1;
    logic                  valid_out2;
    logic                  valid_out3;

    modport master (
        output data_in, valid_in,
        input  out0, out1, out2, out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3
    );

    modport slave (
        input  data_in, valid_in,
        output out0, out1, out2, out3,
        output valid_out0, valid_out1, valid_out2, valid_out3
    );
endinterface

// File: rtl/phy_rx_unstriping.sv
// Regroups a one-byte-per-clock striped stream onto four lanes (lane 0 first),
// emitting full words and gap-terminated partial words with saturating statistics.
module phy_rx_unstriping #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    phy_rx_unstriping_if.slave    bus,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  partial_count,
    output logic                  busy
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [1:0]            idx;
    logic [1:0]            next_idx;
    logic                  store_en;
    logic                  emit_full;
    logic                  emit_partial;

    // Lane 3 never needs staging: the 4th byte goes straight to the output register.
    logic [DATA_WIDTH-1:0] stage0;
    logic [DATA_WIDTH-1:0] stage1;
    logic [DATA_WIDTH-1:0] stage2;

    logic [DATA_WIDTH-1:0] lane0;
    logic [DATA_WIDTH-1:0] lane1;
    logic [DATA_WIDTH-1:0] lane2;
    logic [DATA_WIDTH-1:0] lane3;
    logic [3:0]            lane_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    always_comb begin
        next_state   = state;
        next_idx     = idx;
        store_en     = 1'b0;
        emit_full    = 1'b0;
        emit_partial = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid_in) begin
                    store_en   = 1'b1;
                    next_idx   = 2'd1;
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.valid_in) begin
                    if (idx == 2'd3) begin
                        emit_full = 1'b1;
                        next_idx  = 2'd0;
                    end else begin
                        store_en = 1'b1;
                        next_idx = idx + 2'd1;
                    end
                end else begin
                    // A gap always ends the word; idx==0 means the boundary was already clean.
                    emit_partial = (idx != 2'd0);
                    next_idx     = 2'd0;
                    next_state   = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_idx   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage0        <= '0;
            stage1        <= '0;
            stage2        <= '0;
            lane0         <= '0;
            lane1         <= '0;
            lane2         <= '0;
            lane3         <= '0;
            lane_valid    <= 4'b0000;
            word_count    <= '0;
            partial_count <= '0;
        end else begin
            lane_valid <= 4'b0000;
            if (store_en) begin
                case (idx)
                    2'd0:    stage0 <= bus.data_in;
                    2'd1:    stage1 <= bus.data_in;
                    2'd2:    stage2 <= bus.data_in;
                    default: ;
                endcase
            end
            if (emit_full) begin
                lane0      <= stage0;
                lane1      <= stage1;
                lane2      <= stage2;
                lane3      <= bus.data_in;
                lane_valid <= 4'b1111;
                if (word_count != '1) begin
                    word_count <= word_count + CNT_WIDTH'(1);
                end
            end else if (emit_partial) begin
                lane0      <= stage0;
                lane1      <= (idx >= 2'd2) ? stage1 : '0;
                lane2      <= (idx == 2'd3) ? stage2 : '0;
                lane3      <= '0;
                lane_valid <= {1'b0, (idx == 2'd3), (idx >= 2'd2), 1'b1};
                if (partial_count != '1) begin
                    partial_count <= partial_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.out0       = lane0;
    assign bus.out1       = lane1;
    assign bus.out2       = lane2;
    assign bus.out3       = lane3;
    assign bus.valid_out0 = lane_valid[0];
    assign bus.valid_out1 = lane_valid[1];
    assign bus.valid_out2 = lane_valid[2];
    assign bus.valid_out3 = lane_valid[3];
    assign busy           = (state == COLLECT);

endmodule

// File: tb/tb_phy_rx_unstriping.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue-based
// model; a second instance with 2-bit counters exercises saturation.
module tb_phy_rx_unstriping;

    logic       clk;
    logic       reset;
    logic [7:0] wc_a;
    logic [7:0] pc_a;
    logic       busy_a;
    logic [1:0] wc_s;
    logic [1:0] pc_s;
    logic       busy_s;

    int total = 0;
    int bad   = 0;

    phy_rx_unstriping_if #(.DATA_WIDTH(8)) bus_a ();
    phy_rx_unstriping_if #(.DATA_WIDTH(8)) bus_s ();

    phy_rx_unstriping #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_a.slave),
        .word_count    (wc_a),
        .partial_count (pc_a),
        .busy          (busy_a)
    );

    phy_rx_unstriping #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_s (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_s.slave),
        .word_count    (wc_s),
        .partial_count (pc_s),
        .busy          (busy_s)
    );

    logic [31:0] lanes_a;
    logic [3:0]  mask_a;
    logic [31:0] lanes_s;
    logic [3:0]  mask_s;
    assign lanes_a = {bus_a.out3, bus_a.out2, bus_a.out1, bus_a.out0};
    assign mask_a  = {bus_a.valid_out3, bus_a.valid_out2, bus_a.valid_out1, bus_a.valid_out0};
    assign lanes_s = {bus_s.out3, bus_s.out2, bus_s.out1, bus_s.out0};
    assign mask_s  = {bus_s.valid_out3, bus_s.valid_out2, bus_s.valid_out1, bus_s.valid_out0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: bytes accumulate in a queue; four bytes make a word, a gap flushes the rest.
    logic [7:0]  q[$];
    logic [31:0] m_lanes;
    logic [3:0]  m_mask;
    int          m_words;
    int          m_parts;
    logic        m_busy;

    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        reset          = r;
        bus_a.valid_in = v;
        bus_a.data_in  = d;
        bus_s.valid_in = v;
        bus_s.data_in  = d;
        @(posedge clk);
        #1;
        m_mask = 4'b0000;
        if (r) begin
            q.delete();
            m_lanes = 32'h0;
            m_words = 0;
            m_parts = 0;
            m_busy  = 1'b0;
        end else if (v) begin
            q.push_back(d);
            m_busy = 1'b1;
            if (q.size() == 4) begin
                m_lanes = {q[3], q[2], q[1], q[0]};
                m_mask  = 4'b1111;
                m_words++;
                q.delete();
            end
        end else begin
            m_busy = 1'b0;
            if (q.size() > 0) begin
                m_lanes = 32'h0;
                for (int i = 0; i < q.size(); i++) begin
                    m_lanes[8*i +: 8] = q[i];
                    m_mask[i]         = 1'b1;
                end
                m_parts++;
                q.delete();
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 8'hAB);
            total++;
            if ({lanes_a, mask_a, wc_a, pc_a, busy_a} !== 53'h0) begin
                bad++;
                $display("[TB] FAIL reset_outputs: got lanes=%h mask=%b wc=%0d pc=%0d busy=%b expected all zero",
                         lanes_a, mask_a, wc_a, pc_a, busy_a);
            end
        end
    endtask

    task automatic test_full_word();
        logic [7:0] bytes_in [4] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, bytes_in[i]);
            total++;
            if (mask_a !== ((i == 3) ? 4'b1111 : 4'b0000)) begin
                bad++;
                $display("[TB] FAIL full_mask_%0d: got %b expected %b", i, mask_a, (i == 3) ? 4'b1111 : 4'b0000);
            end
        end
        total++;
        if (lanes_a !== 32'hCCDDEEFF || wc_a !== 8'd1 || busy_a !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_word: got lanes=%h wc=%0d busy=%b expected CCDDEEFF 1 1", lanes_a, wc_a, busy_a);
        end
        cycle(1'b0, 1'b0, 8'h00);
        total++;
        if (lanes_a !== 32'hCCDDEEFF || mask_a !== 4'b0000 || pc_a !== 8'd0 || busy_a !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_after_gap: got lanes=%h mask=%b pc=%0d busy=%b expected CCDDEEFF 0000 0 0",
                     lanes_a, mask_a, pc_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes_in [8] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88};
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, bytes_in[i]);
            total++;
            if (mask_a !== ((i % 4 == 3) ? 4'b1111 : 4'b0000)) begin
                bad++;
                $display("[TB] FAIL b2b_mask_%0d: got %b expected %b", i, mask_a, (i % 4 == 3) ? 4'b1111 : 4'b0000);
            end
        end
        total++;
        if (lanes_a !== 32'h8899AABB || wc_a !== 8'd2 || pc_a !== 8'd0) begin
            bad++;
            $display("[TB] FAIL b2b_second_word: got lanes=%h wc=%0d pc=%0d expected 8899AABB 2 0", lanes_a, wc_a, pc_a);
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_partial();
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h55);
        cycle(1'b0, 1'b1, 8'h77);
        cycle(1'b0, 1'b0, 8'h00);
        total++;
        if (lanes_a !== 32'h00007755 || mask_a !== 4'b0011 || pc_a !== 8'd1 || busy_a !== 1'b0 || wc_a !== 8'd0) begin
            bad++;
            $display("[TB] FAIL partial_two: got lanes=%h mask=%b pc=%0d wc=%0d busy=%b expected 00007755 0011 1 0 0",
                     lanes_a, mask_a, pc_a, wc_a, busy_a);
        end
        cycle(1'b0, 1'b0, 8'h00);
        total++;
        if (mask_a !== 4'b0000 || lanes_a !== 32'h00007755) begin
            bad++;
            $display("[TB] FAIL partial_pulse: got mask=%b lanes=%h expected 0000 00007755", mask_a, lanes_a);
        end
        cycle(1'b0, 1'b1, 8'h3C);
        cycle(1'b0, 1'b0, 8'h00);
        total++;
        if (lanes_a !== 32'h0000003C || mask_a !== 4'b0001 || pc_a !== 8'd2) begin
            bad++;
            $display("[TB] FAIL partial_one: got lanes=%h mask=%b pc=%0d expected 0000003C 0001 2", lanes_a, mask_a, pc_a);
        end
    endtask

    task automatic test_reset_mid_word();
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h11);
        cycle(1'b0, 1'b1, 8'h22);
        cycle(1'b0, 1'b1, 8'h33);
        cycle(1'b1, 1'b1, 8'h99);
        total++;
        if (mask_a !== 4'b0000 || wc_a !== 8'd0 || pc_a !== 8'd0 || busy_a !== 1'b0 || lanes_a !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midreset_discard: got mask=%b wc=%0d pc=%0d busy=%b lanes=%h expected all zero",
                     mask_a, wc_a, pc_a, busy_a, lanes_a);
        end
        cycle(1'b0, 1'b1, 8'h44);
        cycle(1'b0, 1'b1, 8'h55);
        cycle(1'b0, 1'b1, 8'h66);
        cycle(1'b0, 1'b1, 8'h77);
        total++;
        if (lanes_a !== 32'h77665544 || mask_a !== 4'b1111 || wc_a !== 8'd1 || pc_a !== 8'd0) begin
            bad++;
            $display("[TB] FAIL midreset_next_word: got lanes=%h mask=%b wc=%0d pc=%0d expected 77665544 1111 1 0",
                     lanes_a, mask_a, wc_a, pc_a);
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_saturation();
        int exp_w;
        cycle(1'b1, 1'b0, 8'h00);
        for (int w = 1; w <= 5; w++) begin
            for (int b = 0; b < 4; b++) begin
                cycle(1'b0, 1'b1, 8'(w * 16 + b));
            end
            exp_w = (w > 3) ? 3 : w;
            total++;
            if (mask_s !== 4'b1111 || wc_s !== 2'(exp_w) || lanes_s !== {8'(w*16+3), 8'(w*16+2), 8'(w*16+1), 8'(w*16)}) begin
                bad++;
                $display("[TB] FAIL sat_word_%0d: got mask=%b wc=%0d lanes=%h expected 1111 %0d", w, mask_s, wc_s, lanes_s, exp_w);
            end
        end
        total++;
        if (wc_a !== 8'd5) begin
            bad++;
            $display("[TB] FAIL sat_wide_count: got %0d expected 5", wc_a);
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic       r;
        logic       v;
        logic [7:0] d;
        int         ew;
        int         ep;
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 80);
            d = 8'($urandom);
            cycle(r, v, d);
            total++;
            if (lanes_a !== m_lanes || mask_a !== m_mask || busy_a !== m_busy) begin
                bad++;
                $display("[TB] FAIL rand_lanes_%0d: got lanes=%h mask=%b busy=%b expected %h %b %b",
                         i, lanes_a, mask_a, busy_a, m_lanes, m_mask, m_busy);
            end
            ew = (m_words > 255) ? 255 : m_words;
            ep = (m_parts > 255) ? 255 : m_parts;
            total++;
            if (wc_a !== 8'(ew) || pc_a !== 8'(ep)) begin
                bad++;
                $display("[TB] FAIL rand_counts_%0d: got wc=%0d pc=%0d expected %0d %0d", i, wc_a, pc_a, ew, ep);
            end
            ew = (m_words > 3) ? 3 : m_words;
            ep = (m_parts > 3) ? 3 : m_parts;
            total++;
            if (wc_s !== 2'(ew) || pc_s !== 2'(ep) || mask_s !== m_mask || lanes_s !== m_lanes) begin
                bad++;
                $display("[TB] FAIL rand_sat_%0d: got wc=%0d pc=%0d mask=%b expected %0d %0d %b",
                         i, wc_s, pc_s, mask_s, ew, ep, m_mask);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus_a.valid_in = 1'b0;
        bus_a.data_in  = 8'h00;
        bus_s.valid_in = 1'b0;
        bus_s.data_in  = 8'h00;
        q.delete();
        m_lanes = 32'h0;
        m_mask  = 4'b0000;
        m_words = 0;
        m_parts = 0;
        m_busy  = 1'b0;
        test_reset();
        test_full_word();
        test_back_to_back();
        test_partial();
        test_reset_mid_word();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
